// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory arbiter and its round-robin picker.
package dm_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESP   = 2'd2,
        LOCKED = 2'd3
    } dm_state_e;

    localparam int DM_DATA_WIDTH = 32;
    localparam int DM_ADDR_WIDTH = 10;

    // Index following idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or after start,
// wrapping from N-1 back to 0. Shared by the data- and instruction-memory ports.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] winner,
    output logic          valid
);

    // Scan from the farthest candidate back toward start so the closest requester wins last.
    always_comb begin
        int idx;
        idx    = 0;
        winner = start;
        valid  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = IW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shared data-memory responder: serializes core load/store requests onto the
// single-port synchronous memory with round-robin fairness and optional locking.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CORES-1:0]            core_req,
    input  logic [CORES-1:0]            core_we,
    input  logic [CORES-1:0]            core_lock,
    input  logic [CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [CORES*DATA_WIDTH-1:0] core_wdata,
    output logic [CORES-1:0]            core_ack,
    output logic [DATA_WIDTH-1:0]       core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);

    localparam int IW = (CORES > 1) ? $clog2(CORES) : 1;

    dm_state_e             state, state_n;
    logic [IW-1:0]         owner, owner_n;
    logic [IW-1:0]         rr_ptr, rr_ptr_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;

    logic [IW-1:0]         pick_idx;
    logic                  pick_vld;

    logic                  own_req;
    logic                  own_we;
    logic                  own_lock;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_wdata;

    rr_picker #(
        .N  (CORES),
        .IW (IW)
    ) u_picker (
        .req    (core_req),
        .start  (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // Select the current owner's request fields out of the packed core buses.
    always_comb begin
        own_req   = core_req[owner];
        own_we    = core_we[owner];
        own_lock  = core_lock[owner];
        own_addr  = core_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = core_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state logic and memory/ack outputs; reset blanks every output in the same cycle
    // so a store caught in ISSUE never reaches the memory and a pending ack is dropped.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        rdata_n    = rdata_q;
        core_ack   = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_n = pick_idx;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // Owner inputs go straight to the memory; a store commits on this edge.
                mem_en    = 1'b1;
                mem_we    = own_we;
                mem_addr  = own_addr;
                mem_wdata = own_wdata;
                state_n   = RESP;
            end
            RESP: begin
                // Completes regardless of whether req is still high, so a dropped req cannot hang us.
                core_ack[owner] = 1'b1;
                if (!own_we) begin
                    rdata_n = mem_rdata;
                end
                rr_ptr_n = IW'(wrap_inc(int'(owner), CORES));
                state_n  = own_lock ? LOCKED : IDLE;
            end
            LOCKED: begin
                // Other cores are ignored; rr_ptr already points past the owner.
                if (own_req) begin
                    state_n = ISSUE;
                end else if (!own_lock) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (reset) begin
            core_ack  = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // Load data is forwarded in the ack cycle and held afterwards; stores leave it untouched.
    always_comb begin
        core_rdata = reset ? '0 : rdata_n;
    end

    // State, ownership, round-robin pointer and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            rr_ptr  <= rr_ptr_n;
            rdata_q <= rdata_n;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port synchronous memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, we, lock;
    logic [39:0] core_addr;
    logic [127:0] core_wdata;
    logic [3:0]  core_ack;
    logic [31:0] core_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;

    int n_chk;
    int n_err;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (req),
        .core_we    (we),
        .core_lock  (lock),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Read-first synchronous memory; the poke port preloads it.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input int d);
        poke_en   = 1'b1;
        poke_addr = 10'(a);
        poke_data = 32'(d);
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic set_core(input int k, input logic r, input logic w, input logic l,
                            input int a, input int d);
        req[k]  = r;
        we[k]   = w;
        lock[k] = l;
        core_addr[k*10 +: 10]  = 10'(a);
        core_wdata[k*32 +: 32] = 32'(d);
    endtask

    // All four cores load addresses 10..13 at once; expect order 0,1,2,3 spaced 3 cycles.
    task automatic contention(input string tag);
        int order[$];
        int when[$];
        int cyc;
        for (int k = 0; k < 4; k++) set_core(k, 1'b1, 1'b0, 1'b0, 10 + k, 0);
        cyc = 0;
        while (order.size() < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (core_ack != 4'b0) begin
                int k;
                k = 0;
                for (int j = 0; j < 4; j++) if (core_ack[j]) k = j;
                check({tag, "_onehot"}, 64'($countones(core_ack)), 64'd1);
                check({tag, "_rdata"}, core_rdata, 64'(100 + k));
                order.push_back(k);
                when.push_back(cyc);
                req[k] = 1'b0;
            end
        end
        check({tag, "_count"}, 64'(order.size()), 64'd4);
        for (int i = 0; i < order.size(); i++) begin
            check({tag, "_order"}, 64'(order[i]), 64'(i));
            check({tag, "_gap"}, 64'(when[i] - ((i == 0) ? 0 : when[i-1])), (i == 0) ? 64'd2 : 64'd3);
        end
    endtask

    initial begin
        int step, last, cyc;
        bit drop_next, released, c2_seen;
        int f_order[$];
        int f_when[$];

        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        req = '0; we = '0; lock = '0;
        core_addr = '0; core_wdata = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;

        // Preload memory while held in reset.
        poke(5, 9);
        poke(0, 0);
        for (int k = 0; k < 4; k++) poke(10 + k, 100 + k);
        poke(3, 30);
        poke(4, 40);
        poke(20, 55);
        poke(8, 123);
        poke(6, 66);

        check("rst_ack", core_ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", core_rdata, 0);
        reset = 1'b0;
        tick();

        // Single load: core 2 reads addr 5.
        set_core(2, 1'b1, 1'b0, 1'b0, 5, 0);
        tick();
        check("ld_issue_en", mem_en, 1);
        check("ld_issue_we", mem_we, 0);
        check("ld_issue_addr", mem_addr, 5);
        check("ld_issue_noack", core_ack, 0);
        tick();
        check("ld_ack", core_ack, 4'b0100);
        check("ld_rdata", core_rdata, 9);
        req[2] = 1'b0;
        tick();
        check("ld_ack_gone", core_ack, 0);
        check("ld_rdata_hold", core_rdata, 9);

        // Single store: core 0 writes 14 to addr 0.
        set_core(0, 1'b1, 1'b1, 1'b0, 0, 14);
        tick();
        check("st_issue_en", mem_en, 1);
        check("st_issue_we", mem_we, 1);
        check("st_issue_addr", mem_addr, 0);
        check("st_issue_wdata", mem_wdata, 14);
        tick();
        check("st_ack", core_ack, 4'b0001);
        check("st_mem", mem[0], 14);
        check("st_rdata_hold", core_rdata, 9);
        req[0] = 1'b0;
        we[0]  = 1'b0;
        tick();

        // Reset to bring rr_ptr back to 0, then contention twice.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_rdata", core_rdata, 0);
        contention("cont1");
        tick();
        contention("cont2");
        tick();

        // Lock swap: core 1 locked for four accesses, core 2 waiting.
        set_core(1, 1'b1, 1'b0, 1'b1, 3, 0);
        set_core(2, 1'b1, 1'b0, 1'b0, 20, 0);
        step = 0; last = 0; cyc = 0;
        drop_next = 1'b0; released = 1'b0; c2_seen = 1'b0;
        while (!c2_seen && cyc < 60) begin
            tick();
            cyc++;
            if (drop_next) begin
                lock[1]   = 1'b0;
                drop_next = 1'b0;
                released  = 1'b1;
            end
            if (core_ack[2]) begin
                check("lk_c2_after_release", 64'(released), 64'd1);
                check("lk_c2_rdata", core_rdata, 55);
                c2_seen = 1'b1;
                req[2]  = 1'b0;
            end
            if (core_ack[1]) begin
                check("lk_c1_gap", 64'(cyc - last), (step == 0) ? 64'd2 : 64'd3);
                last = cyc;
                if (step == 0) check("lk_ld3", core_rdata, 30);
                if (step == 1) check("lk_ld4", core_rdata, 40);
                step++;
                case (step)
                    1: set_core(1, 1'b1, 1'b0, 1'b1, 4, 0);
                    2: set_core(1, 1'b1, 1'b1, 1'b1, 3, 11);
                    3: set_core(1, 1'b1, 1'b1, 1'b1, 4, 5);
                    default: begin
                        req[1]    = 1'b0;
                        we[1]     = 1'b0;
                        drop_next = 1'b1;
                    end
                endcase
            end
        end
        check("lk_c2_acked", 64'(c2_seen), 64'd1);
        check("lk_steps", 64'(step), 64'd4);
        check("lk_mem3", mem[3], 11);
        check("lk_mem4", mem[4], 5);
        tick();

        // Reset during ISSUE of a store of 7 to addr 8.
        set_core(0, 1'b1, 1'b1, 1'b0, 8, 7);
        tick();
        check("rsti_pre_en", mem_en, 1);
        check("rsti_pre_wdata", mem_wdata, 7);
        reset = 1'b1;
        #1;
        check("rsti_en", mem_en, 0);
        check("rsti_we", mem_we, 0);
        req[0] = 1'b0;
        we[0]  = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rsti_after_ack", core_ack, 0);
        check("rsti_after_en", mem_en, 0);
        check("rsti_after_we", mem_we, 0);
        check("rsti_after_addr", mem_addr, 0);
        check("rsti_after_wdata", mem_wdata, 0);
        check("rsti_after_rdata", core_rdata, 0);
        tick();
        check("rsti_mem8", mem[8], 123);
        check("rsti_no_late_ack", core_ack, 0);

        // Reset during RESP suppresses the ack in that same cycle.
        set_core(1, 1'b1, 1'b0, 1'b0, 6, 0);
        tick();
        tick();
        check("rstr_pre_ack", core_ack, 4'b0010);
        check("rstr_pre_rdata", core_rdata, 66);
        reset = 1'b1;
        #1;
        check("rstr_ack", core_ack, 0);
        req[1] = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rstr_idle_ack", core_ack, 0);

        // Req dropped during ISSUE: the access still completes.
        set_core(0, 1'b1, 1'b0, 1'b0, 6, 0);
        tick();
        req[0] = 1'b0;
        tick();
        check("drop_ack", core_ack, 4'b0001);
        check("drop_rdata", core_rdata, 66);
        tick();
        check("drop_idle", core_ack, 0);

        // Fairness: cores 0 and 3 keep requesting; rr_ptr is 1 so core 3 goes first.
        set_core(0, 1'b1, 1'b0, 1'b0, 10, 0);
        set_core(3, 1'b1, 1'b0, 1'b0, 13, 0);
        cyc = 0;
        while (f_order.size() < 6 && cyc < 60) begin
            tick();
            cyc++;
            if (core_ack != 4'b0) begin
                int k;
                k = core_ack[3] ? 3 : 0;
                check("fair_rdata", core_rdata, 64'(100 + k));
                f_order.push_back(k);
                f_when.push_back(cyc);
            end
        end
        req = '0;
        check("fair_count", 64'(f_order.size()), 64'd6);
        for (int i = 0; i < f_order.size(); i++) begin
            check("fair_order", 64'(f_order[i]), (i % 2 == 0) ? 64'd3 : 64'd0);
            if (i >= 2) check("fair_wait", 64'(f_when[i] - f_when[i-2]), 64'd6);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
